box_controller: RTL

Initiator-side sequencer that drives a prisoner_box through its one-hot command protocol. Upstream logic issues single store or fetch requests over a valid/ready handshake. The controller generates the timed command sequence, guard key and write data toward the box, captures the box read data, and returns a one-cycle response. It sits between the test/host logic and the box, replacing hand-driven command stimulus.

---
 rtl/box_controller.sv | 139 +++++++++++++
 1 files changed

// File: rtl/box_controller.sv
// Initiator-side sequencer for the prisoner_box one-hot command protocol.
// Accepts single store/fetch requests and replays them as timed box commands.
module box_controller #(
  parameter int DATA_W = 8,
  parameter int KEY_W  = 32,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [DATA_W-1:0] req_data,
  input  logic [KEY_W-1:0]  req_key,
  output logic              resp_valid,
  output logic              resp_op,
  output logic [DATA_W-1:0] resp_data,
  output logic [2:0]        box_state,
  output logic [DATA_W-1:0] box_wdata,
  output logic [KEY_W-1:0]  box_key,
  input  logic [DATA_W-1:0] box_rdata,
  output logic [CNT_W-1:0]  store_cnt,
  output logic [CNT_W-1:0]  fetch_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_STORE, S_OPEN, S_HOLD, S_DONE} state_t;

  localparam logic [3:0] RD_LAT_C = 4'(RD_LAT);

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_hold;
  logic                r_op;
  logic                r_ready;
  logic [2:0]          r_box_state;
  logic [DATA_W-1:0]   r_box_wdata;
  logic [KEY_W-1:0]    r_box_key;
  logic                r_resp_valid;
  logic                r_resp_op;
  logic [DATA_W-1:0]   r_resp_data;
  logic [CNT_W-1:0]    r_store_cnt;
  logic [CNT_W-1:0]    r_fetch_cnt;

  logic                w_accept;
  logic                w_last_hold;
  logic [2:0]          w_box_state;
  logic [DATA_W-1:0]   w_box_wdata;
  logic [KEY_W-1:0]    w_box_key;

  assign w_accept    = (r_state == S_IDLE) && req_valid && r_ready;
  assign w_last_hold = (r_state == S_HOLD) && (w_next == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_hold  <= 4'd0;
      r_op    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept)
        r_op <= req_op;
      if (w_next == S_HOLD)
        r_hold <= (r_state == S_HOLD) ? r_hold - 4'd1
                : (r_state == S_OPEN) ? RD_LAT_C : 4'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:          if (w_accept) w_next = req_op ? S_OPEN : S_STORE;
      S_STORE, S_OPEN: w_next = S_HOLD;
      S_HOLD:          if (r_hold <= 4'd1) w_next = S_DONE;
      S_DONE:          w_next = S_IDLE;
      default:         w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it;
  // STORE/OPEN are only entered on an accept, so the live request fields are used.
  always_comb begin
    w_box_state = 3'b000;
    w_box_wdata = '0;
    w_box_key   = '0;
    case (w_next)
      S_STORE: begin
        w_box_state = 3'b001;
        w_box_wdata = req_data;
        w_box_key   = req_key;
      end
      S_OPEN: begin
        w_box_state = 3'b010;
        w_box_key   = req_key;
      end
      S_HOLD:  w_box_state = 3'b100;
      default: w_box_state = 3'b000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready      <= 1'b0;
      r_box_state  <= 3'b000;
      r_box_wdata  <= '0;
      r_box_key    <= '0;
      r_resp_valid <= 1'b0;
      r_resp_op    <= 1'b0;
      r_resp_data  <= '0;
      r_store_cnt  <= '0;
      r_fetch_cnt  <= '0;
    end else begin
      r_ready      <= (w_next == S_IDLE);
      r_box_state  <= w_box_state;
      r_box_wdata  <= w_box_wdata;
      r_box_key    <= w_box_key;
      r_resp_valid <= (w_next == S_DONE);
      if (w_next == S_DONE)
        r_resp_op <= r_op;
      if (w_last_hold && r_op)
        r_resp_data <= box_rdata;
      if (r_state == S_DONE) begin
        if (r_op) r_fetch_cnt <= r_fetch_cnt + 1'b1;
        else      r_store_cnt <= r_store_cnt + 1'b1;
      end
    end
  end

  assign req_ready  = r_ready;
  assign box_state  = r_box_state;
  assign box_wdata  = r_box_wdata;
  assign box_key    = r_box_key;
  assign resp_valid = r_resp_valid;
  assign resp_op    = r_resp_op;
  assign resp_data  = r_resp_data;
  assign store_cnt  = r_store_cnt;
  assign fetch_cnt  = r_fetch_cnt;

endmodule
